universal_shift_register: RTL

Parametrised successor to the single-bit serial shift register: an N-bit register that shifts in W-bit lanes. It supports left/right logical shift, rotate, arithmetic right shift, parallel load and clear, and counts lane shifts to flag a completed frame. It sits between serial front-ends and word-wide datapaths as the common serialiser/deserialiser primitive.

---
 rtl/universal_shift_register.sv | 139 +++++++++++++
 1 files changed

// File: rtl/universal_shift_register.sv
// universal_shift_register
//   N-bit register that shifts in W-bit lanes. It supports logical shift left
//   and right, rotate left and right, arithmetic shift right, parallel load
//   and clear. It counts lane shifts and pulses frame_done when a full frame
//   of N/W lanes has been shifted.
//
// Ports
//   clk        : clock; all state updates on the rising edge
//   rst        : asynchronous active-low reset
//   mode[2:0]  : operation select
//                000 hold, 001 shl, 010 shr, 011 rol, 100 ror,
//                101 asr, 110 load, 111 clear
//   sin_l[W]   : lane entering the LSB end on shift left
//   sin_r[W]   : lane entering the MSB end on shift right
//   pdata_in[N]: parallel load data
//   data_out[N]: register contents
//   sout_l[W]  : top lane of data_out (leaves on the next left shift)
//   sout_r[W]  : bottom lane of data_out (leaves on the next right shift)
//   shift_cnt  : lane shifts since the last frame boundary, load, clear or reset
//   frame_done : one-cycle pulse after the FRAME-th shift of a frame
module universal_shift_register #(
  parameter int N = 32,
  parameter int W = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [2:0]            mode,
  input  logic [W-1:0]          sin_l,
  input  logic [W-1:0]          sin_r,
  input  logic [N-1:0]          pdata_in,
  output logic [N-1:0]          data_out,
  output logic [W-1:0]          sout_l,
  output logic [W-1:0]          sout_r,
  output logic [((N/W) > 1 ? $clog2(N/W) : 1)-1:0] shift_cnt,
  output logic                  frame_done
);

  localparam int FRAME = N / W;
  localparam int CW    = (FRAME > 1) ? $clog2(FRAME) : 1;

  localparam logic [2:0] MODE_HOLD  = 3'b000;
  localparam logic [2:0] MODE_SHL   = 3'b001;
  localparam logic [2:0] MODE_SHR   = 3'b010;
  localparam logic [2:0] MODE_ROL   = 3'b011;
  localparam logic [2:0] MODE_ROR   = 3'b100;
  localparam logic [2:0] MODE_ASR   = 3'b101;
  localparam logic [2:0] MODE_LOAD  = 3'b110;
  localparam logic [2:0] MODE_CLEAR = 3'b111;

  logic [N-1:0]  data_reg;
  logic [N-1:0]  data_next;
  logic [CW-1:0] cnt_reg;
  logic [CW-1:0] cnt_next;
  logic          done_reg;
  logic          done_next;

  // Candidate results for every shift-class operation.
  logic [N-1:0] shl_val;
  logic [N-1:0] shr_val;
  logic [N-1:0] rol_val;
  logic [N-1:0] ror_val;
  logic [N-1:0] asr_val;

  // When a lane is the whole register the "remaining bits" slice would be
  // empty, so that case is built separately.
  generate
    if (W == N) begin : g_full_lane
      assign shl_val = sin_l;
      assign shr_val = sin_r;
      assign rol_val = data_reg;
      assign ror_val = data_reg;
      assign asr_val = {N{data_reg[N-1]}};
    end else begin : g_part_lane
      assign shl_val = {data_reg[N-W-1:0], sin_l};
      assign shr_val = {sin_r, data_reg[N-1:W]};
      assign rol_val = {data_reg[N-W-1:0], data_reg[N-1:N-W]};
      assign ror_val = {data_reg[W-1:0], data_reg[N-1:W]};
      assign asr_val = {{W{data_reg[N-1]}}, data_reg[N-1:W]};
    end
  endgenerate

  // Data path next state.
  always_comb begin
    data_next = data_reg;
    case (mode)
      MODE_HOLD:  data_next = data_reg;
      MODE_SHL:   data_next = shl_val;
      MODE_SHR:   data_next = shr_val;
      MODE_ROL:   data_next = rol_val;
      MODE_ROR:   data_next = ror_val;
      MODE_ASR:   data_next = asr_val;
      MODE_LOAD:  data_next = pdata_in;
      MODE_CLEAR: data_next = '0;
      default:    data_next = data_reg;
    endcase
  end

  // Frame counter: every shift-class operation is one lane shift, whatever
  // its direction. The counter wraps at FRAME and flags the wrap.
  always_comb begin
    cnt_next  = cnt_reg;
    done_next = 1'b0;
    case (mode)
      MODE_SHL, MODE_SHR, MODE_ROL, MODE_ROR, MODE_ASR: begin
        if (cnt_reg == CW'(FRAME - 1)) begin
          cnt_next  = '0;
          done_next = 1'b1;
        end else begin
          cnt_next  = cnt_reg + CW'(1);
        end
      end
      MODE_LOAD, MODE_CLEAR: begin
        cnt_next = '0;
      end
      default: begin
        cnt_next = cnt_reg;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_reg <= '0;
      cnt_reg  <= '0;
      done_reg <= 1'b0;
    end else begin
      data_reg <= data_next;
      cnt_reg  <= cnt_next;
      done_reg <= done_next;
    end
  end

  assign data_out   = data_reg;
  assign sout_l     = data_reg[N-1:N-W];
  assign sout_r     = data_reg[W-1:0];
  assign shift_cnt  = cnt_reg;
  assign frame_done = done_reg;

endmodule
